// File: rtl/race_game_ctrl_if.sv
// Frame-tick/button inputs and registered game-state outputs shared between
// race_game_ctrl (slave) and whoever drives the buttons (master).
interface race_game_ctrl_if;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_start;
    logic [9:0] carro_h_pos;
    logic [8:0] carro_v_pos;
    logic [9:0] obs1_h_pos;
    logic [8:0] obs1_v_pos;
    logic [9:0] obs2_h_pos;
    logic [8:0] obs2_v_pos;
    logic [9:0] lfsr;
    logic [7:0] score;
    logic       crashed;

    modport master (
        output frame_tick, btn_left, btn_right, btn_start,
        input  carro_h_pos, carro_v_pos, obs1_h_pos, obs1_v_pos,
        input  obs2_h_pos, obs2_v_pos, lfsr, score, crashed
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_start,
        output carro_h_pos, carro_v_pos, obs1_h_pos, obs1_v_pos,
        output obs2_h_pos, obs2_v_pos, lfsr, score, crashed
    );
endinterface

// File: rtl/race_game_ctrl.sv
// Per-frame game-state engine: car, two obstacles, lane LFSR, score and speed.
// Define SPEEDUP_EN to build the dodge counter that raises obstacle speed.
module race_game_ctrl #(
    parameter int unsigned CAR_V_POS     = 400,
    parameter int unsigned CAR_STEP      = 4,
    parameter int unsigned H_MIN         = 120,
    parameter int unsigned H_MAX         = 470,
    parameter int unsigned OBS_RESPAWN_V = 480,
    parameter int unsigned OBS2_OFFSET   = 240,
    parameter logic [9:0]  LFSR_SEED     = 10'h3FF
) (
    input  logic            clk,
    input  logic            rst,
    race_game_ctrl_if.slave game_io
);

    localparam logic [10:0] CarV     = 11'(CAR_V_POS);
    localparam logic [10:0] ObjSize  = 11'd50;
    localparam logic [10:0] Step     = 11'(CAR_STEP);
    localparam logic [10:0] HMin     = 11'(H_MIN);
    localparam logic [10:0] HMax     = 11'(H_MAX);
    localparam logic [10:0] RespawnV = 11'(OBS_RESPAWN_V);
    localparam logic [9:0]  Lane0    = 10'd159;
    localparam logic [9:0]  Lane1    = 10'd295;
    localparam logic [9:0]  Lane2    = 10'd431;
    localparam logic [8:0]  Obs2VIni = 9'(OBS2_OFFSET);
    localparam logic [2:0]  SpeedIni = 3'd2;

    typedef enum logic [1:0] {StIdle, StRun, StCrash} state_e;

    state_e     state_q, state_d;
    logic [9:0] car_h_q, car_h_d;
    logic [9:0] obs1_h_q, obs1_h_d;
    logic [8:0] obs1_v_q, obs1_v_d;
    logic [9:0] obs2_h_q, obs2_h_d;
    logic [8:0] obs2_v_q, obs2_v_d;
    logic [9:0] lfsr_q, lfsr_d;
    logic [7:0] score_q, score_d;
    logic [2:0] speed;

    logic        tick, start;
    logic        collide;
    logic [10:0] obs1_adv, obs2_adv;
    logic        resp1, resp2;
    logic [1:0]  n_resp;
    logic [8:0]  score_sum;
    logic [7:0]  score_sat;
    logic [9:0]  car_move;
    logic        run_tick, restart;

    function automatic logic [9:0] lane(input logic [1:0] sel);
        case (sel)
            2'd0:    lane = Lane0;
            2'd2:    lane = Lane2;
            default: lane = Lane1;
        endcase
    endfunction

    // 11-bit compares so h+50 / v+50 never wrap.
    function automatic logic hit(input logic [9:0] oh, input logic [8:0] ov,
                                 input logic [9:0] ch);
        logic [10:0] oh11, ov11, ch11;
        oh11 = {1'b0, oh};
        ov11 = {2'b0, ov};
        ch11 = {1'b0, ch};
        hit  = (oh11 < ch11 + ObjSize) && (ch11 < oh11 + ObjSize) &&
               (ov11 < CarV + ObjSize) && (CarV < ov11 + ObjSize);
    endfunction

    assign tick     = game_io.frame_tick;
    assign start    = game_io.btn_start;
    assign collide  = hit(obs1_h_q, obs1_v_q, car_h_q) || hit(obs2_h_q, obs2_v_q, car_h_q);
    assign lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

    assign obs1_adv  = {2'b0, obs1_v_q} + {8'b0, speed};
    assign obs2_adv  = {2'b0, obs2_v_q} + {8'b0, speed};
    assign resp1     = obs1_adv >= RespawnV;
    assign resp2     = obs2_adv >= RespawnV;
    assign n_resp    = {1'b0, resp1} + {1'b0, resp2};
    assign score_sum = {1'b0, score_q} + {7'b0, n_resp};
    assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
    assign run_tick  = (state_q == StRun) && tick && !collide;
    assign restart   = (state_q == StCrash) && tick && start;

    always_comb begin
        logic [10:0] car11, car_dec, car_inc;
        car11    = {1'b0, car_h_q};
        car_dec  = car11 - Step;
        car_inc  = car11 + Step;
        car_move = car_h_q;
        if (game_io.btn_left && !game_io.btn_right) begin
            car_move = (car11 < HMin + Step) ? HMin[9:0] : car_dec[9:0];
        end else if (game_io.btn_right && !game_io.btn_left) begin
            car_move = (car_inc > HMax) ? HMax[9:0] : car_inc[9:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        car_h_d  = car_h_q;
        obs1_h_d = obs1_h_q;
        obs1_v_d = obs1_v_q;
        obs2_h_d = obs2_h_q;
        obs2_v_d = obs2_v_q;
        score_d  = score_q;
        unique case (state_q)
            StIdle: begin
                if (tick && start) state_d = StRun;
            end
            StRun: begin
                if (tick && collide) begin
                    state_d = StCrash;
                end else if (tick) begin
                    car_h_d = car_move;
                    if (resp1) begin
                        obs1_v_d = '0;
                        obs1_h_d = lane(lfsr_q[1:0]);
                    end else begin
                        obs1_v_d = obs1_adv[8:0];
                    end
                    // When both respawn together obs2 draws from the next LFSR pair.
                    if (resp2) begin
                        obs2_v_d = '0;
                        obs2_h_d = resp1 ? lane(lfsr_q[3:2]) : lane(lfsr_q[1:0]);
                    end else begin
                        obs2_v_d = obs2_adv[8:0];
                    end
                    score_d = score_sat;
                end
            end
            StCrash: begin
                if (restart) begin
                    state_d  = StIdle;
                    car_h_d  = Lane1;
                    obs1_h_d = Lane0;
                    obs1_v_d = '0;
                    obs2_h_d = Lane2;
                    obs2_v_d = Obs2VIni;
                    score_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            car_h_q  <= Lane1;
            obs1_h_q <= Lane0;
            obs1_v_q <= '0;
            obs2_h_q <= Lane2;
            obs2_v_q <= Obs2VIni;
            lfsr_q   <= LFSR_SEED;
            score_q  <= '0;
        end else begin
            state_q  <= state_d;
            car_h_q  <= car_h_d;
            obs1_h_q <= obs1_h_d;
            obs1_v_q <= obs1_v_d;
            obs2_h_q <= obs2_h_d;
            obs2_v_q <= obs2_v_d;
            lfsr_q   <= lfsr_d;
            score_q  <= score_d;
        end
    end

`ifdef SPEEDUP_EN
    logic [2:0] speed_q, speed_d;
    logic [3:0] dodge_q, dodge_d;
    logic [4:0] dodge_sum;

    assign speed     = speed_q;
    assign dodge_sum = {1'b0, dodge_q} + {3'b0, n_resp};

    always_comb begin
        speed_d = speed_q;
        dodge_d = dodge_q;
        if (run_tick && (n_resp != 2'd0)) begin
            if (dodge_sum >= 5'd8) begin
                dodge_d = '0;
                speed_d = (speed_q == 3'd7) ? 3'd7 : speed_q + 3'd1;
            end else begin
                dodge_d = dodge_sum[3:0];
            end
        end else if (restart) begin
            speed_d = SpeedIni;
            dodge_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q <= SpeedIni;
            dodge_q <= '0;
        end else begin
            speed_q <= speed_d;
            dodge_q <= dodge_d;
        end
    end
`else
    logic unused_run_tick;

    assign speed           = SpeedIni;
    assign unused_run_tick = run_tick;
`endif

    assign game_io.carro_h_pos = car_h_q;
    assign game_io.carro_v_pos = CarV[8:0];
    assign game_io.obs1_h_pos  = obs1_h_q;
    assign game_io.obs1_v_pos  = obs1_v_q;
    assign game_io.obs2_h_pos  = obs2_h_q;
    assign game_io.obs2_v_pos  = obs2_v_q;
    assign game_io.lfsr        = lfsr_q;
    assign game_io.score       = score_q;
    assign game_io.crashed     = (state_q == StCrash);

endmodule

// File: tb/tb_race_game_ctrl.sv
// Directed bench for race_game_ctrl: a tick-level game model feeds a scoreboard
// queue that is checked after every frame tick, plus fixed-value spot checks.
module tb_race_game_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    race_game_ctrl_if bus ();

    race_game_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .game_io (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference LFSR, advances every non-reset clock.
    logic [9:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 10'h3FF;
        else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    // Game model: 0 idle, 1 run, 2 crash.
    int m_st, m_car, m_o1h, m_o1v, m_o2h, m_o2v, m_score;
    logic [9:0] last_lf;

    logic [71:0] sb_q[$];
    string       tag_q[$];

    function automatic int lane_of(input logic [1:0] s);
        if (s == 2'd0) return 159;
        if (s == 2'd2) return 431;
        return 295;
    endfunction

    function automatic bit hit(input int oh, input int ov, input int ch);
        return (oh < ch + 50) && (ch < oh + 50) && (ov < 450) && (400 < ov + 50);
    endfunction

    task automatic model_reset();
        m_st = 0; m_car = 295; m_o1h = 159; m_o1v = 0;
        m_o2h = 431; m_o2v = 240; m_score = 0;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit s, input logic [9:0] lf);
        bit r1, r2;
        if (m_st == 0) begin
            if (s) m_st = 1;
        end else if (m_st == 1) begin
            if (hit(m_o1h, m_o1v, m_car) || hit(m_o2h, m_o2v, m_car)) begin
                m_st = 2;
            end else begin
                if (l && !r) m_car = (m_car - 4 < 120) ? 120 : m_car - 4;
                if (r && !l) m_car = (m_car + 4 > 470) ? 470 : m_car + 4;
                r1 = (m_o1v + 2 >= 480);
                r2 = (m_o2v + 2 >= 480);
                if (r1) begin m_o1v = 0; m_o1h = lane_of(lf[1:0]); end
                else m_o1v += 2;
                if (r2) begin m_o2v = 0; m_o2h = r1 ? lane_of(lf[3:2]) : lane_of(lf[1:0]); end
                else m_o2v += 2;
                m_score += int'(r1) + int'(r2);
                if (m_score > 255) m_score = 255;
            end
        end else if (s) begin
            model_reset();
        end
    endtask

    function automatic logic [71:0] model_pack();
        return {10'(m_car), 10'(m_o1h), 9'(m_o1v), 10'(m_o2h), 9'(m_o2v), 8'(m_score),
                1'(m_st == 2), 9'd400, 6'd0};
    endfunction

    function automatic logic [71:0] dut_pack();
        return {bus.carro_h_pos, bus.obs1_h_pos, bus.obs1_v_pos, bus.obs2_h_pos,
                bus.obs2_v_pos, bus.score, bus.crashed, bus.carro_v_pos, 6'd0};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sb_check();
        logic [71:0] e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk(t, dut_pack(), e);
    endtask

    task automatic do_tick(input string tag, input bit l, input bit r, input bit s);
        @(negedge clk);
        bus.btn_left = l; bus.btn_right = r; bus.btn_start = s; bus.frame_tick = 1'b1;
        last_lf = m_lfsr;
        model_tick(l, r, s, last_lf);
        sb_q.push_back(model_pack());
        tag_q.push_back(tag);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        sb_check();
    endtask

    // Idle cycles with buttons held: nothing but the LFSR may change.
    task automatic do_wait(input string tag, input int n);
        @(negedge clk);
        bus.btn_left = 1'b1; bus.btn_right = 1'b1; bus.btn_start = 1'b1;
        sb_q.push_back(model_pack());
        tag_q.push_back(tag);
        repeat (n) @(negedge clk);
        sb_check();
        chk({tag, "_lfsr"}, 72'(bus.lfsr), 72'(m_lfsr));
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_start = 1'b0;
    endtask

    task automatic do_reset(input string tag, input bit with_tick);
        @(negedge clk);
        rst = 1'b1;
        bus.frame_tick = with_tick; bus.btn_start = with_tick;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0;
        model_reset();
        sb_q.push_back(model_pack());
        tag_q.push_back(tag);
        @(negedge clk);
        sb_check();
        chk({tag, "_lfsr"}, 72'(bus.lfsr), 72'h3FF);
        rst = 1'b0; bus.frame_tick = 1'b0; bus.btn_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_tick = 1'b0; bus.btn_left = 1'b0;
        bus.btn_right = 1'b0;  bus.btn_start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset with tick+start asserted must still leave the game idle.
        do_reset("reset_tick_ignored", 1'b1);
        for (int i = 0; i < 5; i++) do_tick("idle_tick", 1'b1, 1'b0, 1'b0);
        chk("idle_car", 72'(bus.carro_h_pos), 72'd295);
        chk("idle_obs1_v", 72'(bus.obs1_v_pos), 72'd0);
        chk("idle_obs2_v", 72'(bus.obs2_v_pos), 72'd240);
        chk("idle_score", 72'(bus.score), 72'd0);

        // Right-hold: 10 ticks, then saturation at the road edge.
        do_tick("start", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) do_tick("right", 1'b0, 1'b1, 1'b0);
        chk("car_after_10_right", 72'(bus.carro_h_pos), 72'd335);
        for (int i = 10; i < 100; i++) do_tick("right_sat", 1'b0, 1'b1, 1'b0);
        chk("car_saturated", 72'(bus.carro_h_pos), 72'd470);

        // Car to lane0, obs2 respawns on tick 120, obs1 hits the car on tick 177.
        do_reset("reset_b", 1'b0);
        do_tick("start_c", 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 34; k++) do_tick("left", 1'b1, 1'b0, 1'b0);
        chk("car_lane0", 72'(bus.carro_h_pos), 72'd159);
        for (int k = 35; k <= 119; k++) do_tick("cruise", 1'b0, 1'b0, 1'b0);
        chk("score_before_dodge", 72'(bus.score), 72'd0);
        chk("obs2_v_before_dodge", 72'(bus.obs2_v_pos), 72'd478);
        do_tick("dodge", 1'b0, 1'b0, 1'b0);
        chk("obs2_v_respawn", 72'(bus.obs2_v_pos), 72'd0);
        chk("obs2_h_respawn", 72'(bus.obs2_h_pos), 72'(lane_of(last_lf[1:0])));
        chk("score_one", 72'(bus.score), 72'd1);
        for (int k = 121; k <= 176; k++) do_tick("approach", 1'b0, 1'b0, 1'b0);
        chk("not_yet_crashed", 72'(bus.crashed), 72'd0);
        chk("obs1_v_overlap", 72'(bus.obs1_v_pos), 72'd352);
        do_tick("crash", 1'b0, 1'b0, 1'b0);
        chk("crashed", 72'(bus.crashed), 72'd1);
        for (int i = 0; i < 3; i++) do_tick("frozen", 1'b1, 1'b0, 1'b0);
        chk("frozen_obs1_v", 72'(bus.obs1_v_pos), 72'd352);
        chk("frozen_obs2_v", 72'(bus.obs2_v_pos), 72'd112);
        chk("frozen_car", 72'(bus.carro_h_pos), 72'd159);
        do_tick("restart", 1'b0, 1'b0, 1'b1);
        chk("restart_crashed", 72'(bus.crashed), 72'd0);
        chk("restart_score", 72'(bus.score), 72'd0);
        chk("restart_obs2_v", 72'(bus.obs2_v_pos), 72'd240);
        do_tick("idle_after_restart", 1'b0, 1'b0, 1'b0);
        chk("idle_obs1_still", 72'(bus.obs1_v_pos), 72'd0);

        // Both buttons hold the car; outputs stay put between ticks; reset mid-run.
        do_tick("start_d", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) do_tick("both_btn", 1'b1, 1'b1, 1'b0);
        chk("car_both_hold", 72'(bus.carro_h_pos), 72'd295);
        chk("obs1_v_4_ticks", 72'(bus.obs1_v_pos), 72'd8);
        do_wait("between_ticks", 6);
        do_reset("reset_mid_run", 1'b0);
        do_tick("post_reset_idle", 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/race_game_ctrl.md
Name: race_game_ctrl

Overview:
- Game-state engine directly upstream of the pixel drawer.
- Once per video frame it updates the player-car position, the two obstacle positions, the lane-selection LFSR, the score and the speed.
- All position outputs are registered and held stable between frame ticks, so the drawer sees consistent coordinates across a whole frame.
- One-cycle `frame_tick` comes from the VGA timing generator and is asserted at the end of the visible area.

Parameters:
- CAR_V_POS, 400, fixed car top row (car occupies rows 400..449)
- CAR_STEP, 4, car horizontal pixels per frame
- H_MIN, 120, leftmost car h_pos (road left edge)
- H_MAX, 470, rightmost car h_pos (520-50)
- OBS_RESPAWN_V, 480, obstacle v_pos at or above which it respawns
- OBS2_OFFSET, 240, obstacle-2 initial v_pos stagger
- LFSR_SEED, 10'h3FF, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- btn_left  in  1  move-left request, level
- btn_right  in  1  move-right request, level
- btn_start  in  1  start/restart, level
- carro_h_pos  out  10  car left column
- carro_v_pos  out  9  car top row, constant CAR_V_POS
- obs1_h_pos  out  10  obstacle 1 left column
- obs1_v_pos  out  9  obstacle 1 top row
- obs2_h_pos  out  10  obstacle 2 left column
- obs2_v_pos  out  9  obstacle 2 top row
- lfsr  out  10  current LFSR value
- score  out  8  obstacles dodged, saturating
- crashed  out  1  high in CRASH state

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state changes occur on the rising edge of `clk`; `rst` has priority over everything.
- Reset values:
  - state=IDLE, carro_h_pos=295
  - obs1_h_pos=159, obs1_v_pos=0
  - obs2_h_pos=431, obs2_v_pos=OBS2_OFFSET
  - lfsr=LFSR_SEED, score=0, speed=2, dodge_cnt=0, crashed=0
- Lane centres (h_pos): lane0=159, lane1=295, lane2=431. Lane map from lfsr[1:0]: 0→lane0, 1→lane1, 2→lane2, 3→lane1.
- LFSR: Fibonacci, taps x^10+x^7+1. new bit = lfsr[9]^lfsr[6], shifted into bit0. Advances every clock in every state except during reset. It can never reach all-zeros.
- Collision (combinational on registered values): for either obstacle, (obs_h < car_h+50) && (car_h < obs_h+50) && (obs_v < CAR_V_POS+50) && (CAR_V_POS < obs_v+50). Use 11-bit compares; no truncation.
- FSM:
  - IDLE: outputs hold reset positions. On frame_tick with btn_start=1 → RUN; nothing moves that tick.
  - RUN: acts only on frame_tick.
    - If collision=1 at the tick: → CRASH; no position or score update that tick.
    - Else, car: btn_left only → car_h = max(car_h-CAR_STEP, H_MIN). btn_right only → car_h = min(car_h+CAR_STEP, H_MAX). Both or neither → hold.
    - Else, each obstacle: v+speed < OBS_RESPAWN_V → v += speed. Otherwise respawn: v=0, h=lane(lfsr[1:0]), score += 1 (saturate at 255), dodge_cnt += 1.
    - Both obstacles respawning on the same tick: obs1 uses lfsr[1:0], obs2 uses lfsr[3:2]; score += 2, saturating.
  - CRASH: crashed=1, all positions frozen. On frame_tick with btn_start=1 → IDLE with full reset of positions, score, speed and dodge_cnt (lfsr keeps running).
- Between frame ticks, every output except lfsr is constant.
- frame_tick during reset is ignored.

Optional Feature:
- SPEEDUP_EN defined: when dodge_cnt reaches 8, it clears and speed increments, saturating at 7. Both happen in the same tick as the triggering respawn.
- SPEEDUP_EN undefined: speed is fixed at 2; dodge_cnt logic is not built.

Test Plan:
- Reset, then 5 frame_ticks without start → state IDLE, obs1_v=0, obs2_v=240, car_h=295, score=0.
- Start, then 10 ticks with btn_right → car_h=335. Continue holding to 100 ticks → car_h saturates at 470.
- RUN with car in lane0 (h=159), no buttons; obs2 v reaches 480 at a tick → obs2_v=0, obs2_h=lane(lfsr[1:0]), score=1.
- Force obs1 into lane1 with car_h=295. When obs1_v reaches 352 (overlap), the next tick sets crashed=1. Further ticks leave all positions unchanged. btn_start + tick → IDLE, score=0.
- Hold btn_left and btn_right together for 4 ticks → car_h unchanged. Assert rst mid-RUN → next cycle all outputs equal reset values.
- With SPEEDUP_EN: after 8 dodges, obstacle step becomes 3 px/tick. After 40 dodges speed=7 and stays 7.
